// File: rtl/fetch_ctrl.sv
// fetch_ctrl: LC-3 instruction-fetch sequencer.
//   Runs the fetch phase MAR<-PC (PC<-PC+1), MDR<-M[MAR], IR<-MDR and
//   drives the PC register's load/mux controls for the increment.
//
// Ports
//   i_CLK, i_RST       clock, synchronous active-high reset
//   i_Fetch_Req        start a fetch (sampled only while idle)
//   i_PC               current PC from the PC register
//   i_Mem_Data/i_Mem_R memory read data / data-valid
//   o_MAR              memory address register
//   o_Mem_En           memory read enable
//   o_LD_PC/o_PCMUX    PC register load enable / source select (PC+1)
//   o_MDR, o_IR        memory data register, instruction register
//   o_Busy, o_Done     not idle / one-cycle completion pulse
//   o_Fault            sticky read-timeout flag
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   Defined: a read that sees no i_Mem_R for TIMEOUT_CYCLES cycles aborts
//   to idle and sets o_Fault. Undefined: reads wait forever, o_Fault = 0.
module fetch_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_Fetch_Req,
  input  logic [15:0] i_PC,
  input  logic [15:0] i_Mem_Data,
  input  logic        i_Mem_R,
  output logic [15:0] o_MAR,
  output logic        o_Mem_En,
  output logic        o_LD_PC,
  output logic [1:0]  o_PCMUX,
  output logic [15:0] o_MDR,
  output logic [15:0] o_IR,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_Fault
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_READ = 3'd2;
  localparam logic [2:0] S_LDIR = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // The counter is 8 bits wide, so the limit must fit in 1..255.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("fetch_ctrl: TIMEOUT_CYCLES must be in 1..255");
  end

  logic [2:0] state;

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] tcnt;
  logic       fault;
  // tcnt counts the ready-less READ cycles already elapsed, so the limit
  // is hit in the cycle where one more idle cycle would reach the limit.
  logic       limit;
  assign limit   = (tcnt == 8'(TIMEOUT_CYCLES - 1));
  assign o_Fault = fault;
`else
  assign o_Fault = 1'b0;
`endif

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state <= S_IDLE;
      o_MAR <= 16'h0000;
      o_MDR <= 16'h0000;
      o_IR  <= 16'h0000;
`ifdef FETCH_TIMEOUT_EN
      tcnt  <= 8'd0;
      fault <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (i_Fetch_Req) state <= S_ADDR;
        S_ADDR: begin
          // PC register increments on this same edge; latch the old value.
          o_MAR <= i_PC;
`ifdef FETCH_TIMEOUT_EN
          tcnt  <= 8'd0;
`endif
          state <= S_READ;
        end
        S_READ: begin
          // Ready wins over the timeout when both land in the same cycle.
          if (i_Mem_R) begin
            o_MDR <= i_Mem_Data;
            state <= S_LDIR;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (limit) begin
            fault <= 1'b1;
            state <= S_IDLE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
`endif
        end
        S_LDIR: begin
          o_IR  <= o_MDR;
          state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_PCMUX  = 2'b00;
  assign o_LD_PC  = (state == S_ADDR);
  assign o_Mem_En = (state == S_READ);
  assign o_Busy   = (state != S_IDLE);
  assign o_Done   = (state == S_DONE);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a cycle-age reference model checked
// on every falling edge, plus directed fetches with literal expectations.
module tb_fetch_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, req, mem_r;
  logic [15:0] mem_data, pc, pc_val;
  logic        pc_set;
  logic [15:0] mar, mdr, ir;
  logic        mem_en, ld_pc, busy, done, fault;
  logic [1:0]  pcmux;

  always #5 clk = ~clk;

  fetch_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .i_CLK(clk), .i_RST(rst), .i_Fetch_Req(req), .i_PC(pc),
    .i_Mem_Data(mem_data), .i_Mem_R(mem_r), .o_MAR(mar), .o_Mem_En(mem_en),
    .o_LD_PC(ld_pc), .o_PCMUX(pcmux), .o_MDR(mdr), .o_IR(ir),
    .o_Busy(busy), .o_Done(done), .o_Fault(fault)
  );

  // PC register: loads PC+1 when told to, or a bench preset value.
  always @(posedge clk) begin
    if (pc_set) pc <= pc_val;
    else if (ld_pc && pcmux == 2'b00) pc <= pc + 16'd1;
  end

  int n_pass = 0, n_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a fetch is tracked by its age in cycles since the
  // request was accepted (age 1 = address cycle) and the age at which data
  // arrived. Updated on the falling edge from the inputs about to be sampled.
  bit          m_on = 0, m_act = 0, m_got = 0, m_fault = 0;
  int          m_age = 0, m_got_age = 0, m_wait = 0;
  logic [15:0] m_mar, m_mdr, m_ir;

  always @(negedge clk) begin
    if (m_on) begin
      chk("busy",   busy,   m_act);
      chk("ld_pc",  ld_pc,  m_act && m_age == 1);
      chk("mem_en", mem_en, m_act && m_age >= 2 && !m_got);
      chk("done",   done,   m_act && m_got && m_age == m_got_age + 2);
      chk("pcmux",  pcmux,  2'b00);
      chk("mar",    mar,    m_mar);
      chk("mdr",    mdr,    m_mdr);
      chk("ir",     ir,     m_ir);
      chk("fault",  fault,  m_fault);
    end
    if (rst) begin
      m_on = 1; m_act = 0; m_got = 0; m_fault = 0; m_age = 0;
      m_mar = 16'h0; m_mdr = 16'h0; m_ir = 16'h0;
    end else if (m_on) begin
      if (!m_act) begin
        if (req) begin m_act = 1; m_age = 1; m_got = 0; m_wait = 0; end
      end else if (m_age == 1) begin
        m_mar = pc; m_age = 2;
      end else if (!m_got) begin
        if (mem_r) begin
          m_mdr = mem_data; m_got = 1; m_got_age = m_age; m_age++;
        end else begin
          m_wait++; m_age++;
`ifdef FETCH_TIMEOUT_EN
          if (m_wait == TO) begin m_fault = 1; m_act = 0; end
`endif
        end
      end else if (m_age == m_got_age + 1) begin
        m_ir = m_mdr; m_age++;
      end else begin
        m_act = 0;
      end
    end
  end

  task automatic set_pc(input logic [15:0] v);
    pc_set = 1; pc_val = v;
    @(posedge clk); #2;
    pc_set = 0;
  endtask

  // Runs one fetch. r_delay < 0: i_Mem_R held high; otherwise ready is
  // raised in read cycle r_delay+1. k counts cycles after the first edge.
  task automatic run_fetch(input int r_delay, input bit hold, output int done_k,
                           output int r_k, output int ld_n, output int en_n,
                           output bit faulted);
    bit fin = 0;
    done_k = -1; r_k = -1; ld_n = 0; en_n = 0; faulted = 0;
    req = 1;
    mem_r = (r_delay < 0);
    for (int k = 1; k <= 60 && !fin; k++) begin
      @(posedge clk); #2;
      if (!hold && k == 1) req = 0;
      if (ld_pc) ld_n++;
      if (mem_en) begin
        mem_r = (r_delay < 0) || (en_n >= r_delay);
        if (mem_r && r_k < 0) r_k = k;
        en_n++;
      end else begin
        mem_r = (r_delay < 0);
      end
      if (done) begin done_k = k; fin = 1; end
      else if (k > 1 && !busy) begin faulted = 1; done_k = k; fin = 1; end
    end
    if (!fin) chk("fetch_bound", 0, 1);
    if (r_delay >= 0) mem_r = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dk, rk, ln, en;
    bit ft;
    rst = 1; req = 0; mem_r = 0; mem_data = 16'h0; pc_set = 1; pc_val = 16'h0;
    repeat (2) @(posedge clk);
    #2;
    pc_set = 0;
    chk("rst_busy", busy, 0);
    chk("rst_mar", mar, 16'h0);
    chk("rst_ir", ir, 16'h0);
    chk("rst_fault", fault, 0);
    rst = 0;

    // Basic fetch, ready immediately.
    set_pc(16'h3000);
    mem_data = 16'h1234;
    run_fetch(-1, 0, dk, rk, ln, en, ft);
    chk("t1_done_k", dk, 4);
    chk("t1_ld_n", ln, 1);
    chk("t1_mar", mar, 16'h3000);
    chk("t1_ir", ir, 16'h1234);
    chk("t1_pc", pc, 16'h3001);
    mem_r = 0;
    @(posedge clk); #2;

    // Ready delayed 5 cycles.
    mem_data = 16'hABCD;
    run_fetch(5, 0, dk, rk, ln, en, ft);
    chk("t2_en_n", en, 6);
    chk("t2_done_k", dk, 9);
    chk("t2_r_to_done", dk - rk, 2);
    chk("t2_ld_n", ln, 1);
    chk("t2_mar", mar, 16'h3001);
    chk("t2_ir", ir, 16'hABCD);
    @(posedge clk); #2;

    // Three back-to-back fetches with request held high.
    set_pc(16'h4000);
    for (int i = 0; i < 3; i++) begin
      mem_data = 16'h5000 + 16'(i);
      run_fetch(-1, 1, dk, rk, ln, en, ft);
      if (i == 2) req = 0;
      chk("t3_done_k", dk, (i == 0) ? 4 : 5);
      chk("t3_mar", mar, 16'h4000 + 16'(i));
      chk("t3_ir", ir, 16'h5000 + 16'(i));
    end
    mem_r = 0;
    @(posedge clk); #2;
    chk("t3_idle", busy, 0);
    chk("t3_pc", pc, 16'h4003);

    // Reset while waiting in the read state.
    mem_data = 16'h5555; mem_r = 0; req = 1;
    @(posedge clk); #2; req = 0;
    @(posedge clk); #2;
    chk("t4_in_read", mem_en, 1);
    rst = 1;
    @(posedge clk); #2;
    rst = 0;
    chk("t4_busy", busy, 0);
    chk("t4_mem_en", mem_en, 0);
    chk("t4_done", done, 0);
    chk("t4_ir_not_new", (ir == 16'h5555) ? 1 : 0, 0);
    chk("t4_pc_kept", pc, 16'h4004);
    repeat (3) begin @(posedge clk); #2; chk("t4_no_done", done, 0); end

    // MAR wrap.
    set_pc(16'hFFFF);
    mem_data = 16'h0F0F;
    run_fetch(-1, 0, dk, rk, ln, en, ft);
    mem_r = 0;
    chk("t5_mar", mar, 16'hFFFF);
    chk("t5_pc", pc, 16'h0000);
    chk("t5_done_k", dk, 4);
    @(posedge clk); #2;

`ifdef FETCH_TIMEOUT_EN
    mem_data = 16'h7777;
    run_fetch(-1, 0, dk, rk, ln, en, ft);
    mem_r = 0;
    @(posedge clk); #2;
    mem_data = 16'h9999;
    run_fetch(1000, 0, dk, rk, ln, en, ft);
    chk("t6_faulted", ft, 1);
    chk("t6_fault_k", dk, 6);
    chk("t6_en_n", en, TO);
    chk("t6_fault", fault, 1);
    chk("t6_ir", ir, 16'h7777);
    chk("t6_mdr", mdr, 16'h7777);
    rst = 1;
    @(posedge clk); #2;
    rst = 0;
    chk("t6_fault_clr", fault, 0);
    mem_data = 16'h2468;
    run_fetch(TO - 1, 0, dk, rk, ln, en, ft);
    chk("t7_faulted", ft, 0);
    chk("t7_done_k", dk, 2 + TO + 1);
    chk("t7_fault", fault, 0);
    chk("t7_ir", ir, 16'h2468);
`else
    mem_data = 16'h2468;
    run_fetch(20, 0, dk, rk, ln, en, ft);
    chk("t6_faulted", ft, 0);
    chk("t6_done_k", dk, 24);
    chk("t6_fault", fault, 0);
    chk("t6_ir", ir, 16'h2468);
`endif
    repeat (2) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
